// File: rtl/ysyx_23060075_sram_arbiter.sv
// ysyx_23060075_sram_arbiter
//
// Two-master round-robin arbiter and sequencer for the single read port of
// ysyx_23060075_sram. Master 0 (IFU) and master 1 (LSU) issue word reads on
// a valid/ready request channel and each receive a one-cycle response pulse.
// Each transaction is guarded by a timeout watchdog.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mN_arvalid / mN_araddr    master N read request and address
//   mN_arready                request accepted (combinational, IDLE only)
//   mN_rvalid                 one-cycle response pulse for master N
//   mN_rdata                  response data (shared data register)
//   mN_rerr                   timeout flag, valid with mN_rvalid
//   s_raddr                   SRAM address, held from REQ through WAIT
//   s_rvalid                  SRAM start pulse (one cycle, in REQ)
//   s_rready / s_rdata        SRAM data-ready pulse and data
//   busy                      high whenever the sequencer is not IDLE

`ifndef ysyx_23060075_ISA_WIDTH
`define ysyx_23060075_ISA_WIDTH 32
`endif

module ysyx_23060075_sram_arbiter #(
  parameter int W       = `ysyx_23060075_ISA_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         m0_arvalid,
  input  logic [W-1:0] m0_araddr,
  output logic         m0_arready,
  output logic         m0_rvalid,
  output logic [W-1:0] m0_rdata,
  output logic         m0_rerr,

  input  logic         m1_arvalid,
  input  logic [W-1:0] m1_araddr,
  output logic         m1_arready,
  output logic         m1_rvalid,
  output logic [W-1:0] m1_rdata,
  output logic         m1_rerr,

  output logic [W-1:0] s_raddr,
  output logic         s_rvalid,
  input  logic         s_rready,
  input  logic [W-1:0] s_rdata,

  output logic         busy
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic          last_q;
  logic          gnt_q;
  logic          err_q;
  logic [W-1:0]  addr_q;
  logic [W-1:0]  data_q;
  logic [TW-1:0] tcnt_q;

  logic          winner;
  logic          accept;

  // Round-robin pick: a lone requester always wins; on a tie the master that
  // did not win the previous accept gets the grant.
  always_comb begin
    winner = m1_arvalid;
    if (m0_arvalid && m1_arvalid) begin
      winner = ~last_q;
    end
  end

  // arready is gated by rst so nothing is accepted while reset is held.
  assign accept = (state_q == IDLE) && !rst && (m0_arvalid || m1_arvalid);

  // Next-state and per-state strobes.
  always_comb begin
    state_d    = state_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rvalid   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          m0_arready = ~winner;
          m1_arready = winner;
          state_d    = REQ;
        end
      end
      REQ: begin
        s_rvalid = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (s_rready || (tcnt_q == TLAST)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        m0_rvalid = ~gnt_q;
        m1_rvalid = gnt_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The SRAM samples its address late, so the latched address is presented
  // for the whole REQ/WAIT window and forced to zero elsewhere.
  assign s_raddr  = ((state_q == REQ) || (state_q == WAIT)) ? addr_q : '0;
  assign busy     = (state_q != IDLE);
  assign m0_rdata = data_q;
  assign m1_rdata = data_q;
  assign m0_rerr  = m0_rvalid & err_q;
  assign m1_rerr  = m1_rvalid & err_q;

  // State register plus transaction bookkeeping. s_rready only matters in
  // WAIT, which is what discards stray replies after a timeout or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            gnt_q  <= winner;
            last_q <= winner;
            addr_q <= winner ? m1_araddr : m0_araddr;
          end
        end
        REQ: begin
          tcnt_q <= '0;
        end
        WAIT: begin
          if (s_rready) begin
            data_q <= s_rdata;
            err_q  <= 1'b0;
          end else if (tcnt_q == TLAST) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060075_sram_arbiter.md
# ysyx_23060075_sram_arbiter

Two-master arbiter and sequencer for the single read port of `ysyx_23060075_sram`. Master 0 (IFU) and master 1 (LSU) each issue word reads through a valid/ready request channel and receive a one-cycle response pulse. The block sits between the two masters and the SRAM. It serialises requests with round-robin priority, holds the SRAM address stable for the full transaction, and guards each transaction with a timeout watchdog.

## Interface
Parameters:
- W, default `ysyx_23060075_ISA_WIDTH` (32): address and data width.
- TIMEOUT, default 16: maximum number of WAIT cycles before a transaction is aborted. Legal range is 2..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- m0_arvalid  in  1  master 0 read request.
- m0_araddr  in  W  master 0 address.
- m0_arready  out  1  master 0 request accepted (combinational).
- m0_rvalid  out  1  master 0 response pulse.
- m0_rdata  out  W  master 0 response data.
- m0_rerr  out  1  master 0 timeout flag, valid with m0_rvalid.
- m1_arvalid, m1_araddr, m1_arready, m1_rvalid, m1_rdata, m1_rerr: same as master 0, for master 1.
- s_raddr  out  W  SRAM address.
- s_rvalid  out  1  SRAM start pulse.
- s_rready  in  1  SRAM data-ready pulse.
- s_rdata  in  W  SRAM data.
- busy  out  1  high when state != IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If any mN_arvalid is high, choose a winner, assert its arready in the same cycle, latch addr_q and gnt_q, then go to REQ.
  - If no request is pending, stay in IDLE.
- Arbitration:
  - Exactly one requester high: that requester wins.
  - Both high: the master not equal to last_q wins.
  - last_q updates to the winner on every accept. Reset value is 1, so master 0 wins the first tie.
- REQ: s_rvalid = 1 for exactly this one cycle. Clear the timeout counter `tcnt`. Go to WAIT.
- WAIT:
  - If s_rready = 1: latch s_rdata into data_q, set err_q = 0, go to RESP.
  - Else if tcnt == TIMEOUT-1: set data_q = 0, set err_q = 1, go to RESP.
  - Else: tcnt increments by 1.
- RESP:
  - m[gnt_q]_rvalid = 1 for one cycle, with m[gnt_q]_rdata = data_q and m[gnt_q]_rerr = err_q.
  - The other master's rvalid stays 0.
  - Go to IDLE.
- Address hold: s_raddr = addr_q from REQ through WAIT inclusive. The SRAM samples its address late, not on the start pulse, so addr_q must not change before the transaction leaves WAIT.
- Stray responses: s_rready is ignored in IDLE, REQ and RESP. A late SRAM response after a timeout is discarded and does not affect the next transaction.
- Both mN_rdata outputs are driven from data_q. Masters must qualify data with their own rvalid.
- tcnt width is $clog2(TIMEOUT+1).

## Timing
- Accept: arready is a combinational function of arvalid, valid only in IDLE, and is 0 in every other state. A master must hold arvalid and araddr until it sees arready.
- Request sequence, with accept at cycle T:
  - REQ at T+1, where s_rvalid is high.
  - WAIT from T+2.
  - s_rready seen at cycle R gives RESP at R+1 (mN_rvalid high) and IDLE at R+2.
- Minimum accept-to-rvalid latency is 3 cycles. Back-to-back acceptance is possible at R+2.
- Timeout: with no s_rready, rvalid with rerr=1 appears at T+2+TIMEOUT.
- Reset values: state=IDLE, last_q=1, gnt_q=0, addr_q=0, data_q=0, err_q=0, tcnt=0. All outputs are 0: s_rvalid, s_raddr, arready (arready is held low while rst=1), rvalid, rdata, rerr, busy.
- Reset mid-transaction: rst forces IDLE on the next edge and no response is delivered. An outstanding SRAM reply is then discarded per the stray-response rule. The SRAM's own counter is also cleared by the same rst.
- A new request arriving during RESP is not accepted until IDLE.

## Test plan
- Single read: m0 requests 0x80000000 and the SRAM model returns 0xDEADBEEF after 5 cycles. Expect m0_rvalid for one cycle with rdata=0xDEADBEEF and rerr=0, m1_rvalid never high, and s_rvalid high for exactly one cycle.
- Tie: m0 and m1 both assert arvalid from reset. Expect grant order m0, m1, m0, m1 over 4 transactions, and each response routed to the correct master.
- Address hold: m1 drives 0x100, then changes araddr after arready. Expect s_raddr=0x100 for the whole transaction and returned data to match 0x100.
- Timeout: with TIMEOUT=16 and the SRAM model never raising s_rready, expect rvalid and rerr=1 with rdata=0 exactly 18 cycles after accept. A stray s_rready injected 2 cycles later must produce no rvalid, and the next read must complete normally.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT. Expect busy=0 and all outputs 0 the next cycle, and no rvalid for the aborted request.
- Random stress: 1000 reads with random arvalid on both masters and 1–10 cycle SRAM latency. Expect every accepted request to get exactly one response in order, no starvation (grant gap ≤ 1 transaction), and no response without a preceding accept.
